univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: parallel load plus multi-step shift

---
 rtl/univ_shift_reg.sv | 124 ++++++++++++
 tb/tb_univ_shift_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, multi-step SHR/SHL with serial fill,
// and optional rotate (enabled by defining UNIV_SREG_ROTATE_EN).
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] D_in,
  input  logic [1:0]       op,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] Q_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               ser_q, ser_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               fill_q, fill_d;

  logic               dep_bit;
  logic               fill_bit;
  logic [WIDTH-1:0]   step_q;
  logic [CNT_W-1:0]   shamt_sat;

  // Bit leaving the register on this step; it is also the rotate fill.
  assign dep_bit = left_q ? q_q[WIDTH-1] : q_q[0];

`ifdef UNIV_SREG_ROTATE_EN
  logic rot_q, rot_d;
  assign fill_bit = rot_q ? dep_bit : fill_q;
`else
  logic unused_op_hi;
  assign unused_op_hi = op[1];
  assign fill_bit     = fill_q;
`endif

  assign step_q    = left_q ? {q_q[WIDTH-2:0], fill_bit} : {fill_bit, q_q[WIDTH-1:1]};
  assign shamt_sat = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
`ifdef UNIV_SREG_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          q_d = D_in;
        end else if (start) begin
          if (shamt == '0) begin
            done_d = 1'b1;
          end else begin
            left_d  = op[0];
            fill_d  = ser_in;
            cnt_d   = shamt_sat;
            state_d = SHIFT;
`ifdef UNIV_SREG_ROTATE_EN
            rot_d   = op[1];
`endif
          end
        end
      end
      SHIFT: begin
        q_d   = step_q;
        ser_d = dep_bit;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      fill_q  <= 1'b0;
`ifdef UNIV_SREG_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      fill_q  <= fill_d;
`ifdef UNIV_SREG_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign Q_out   = q_q;
  assign ser_out = ser_q;
  assign done    = done_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_univ_shift_reg;
  localparam int W     = 8;
  localparam int CNT_W = $clog2(W) + 1;
`ifdef UNIV_SREG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, ser_in, start;
  logic [W-1:0]     D_in;
  logic [1:0]       op;
  logic [CNT_W-1:0] shamt;
  logic [W-1:0]     Q_out;
  logic             ser_out, busy, done;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .D_in(D_in), .op(op), .ser_in(ser_in),
    .start(start), .shamt(shamt), .Q_out(Q_out), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; D_in = v;
    tick();
    en = 1'b0; D_in = W'($urandom);
  endtask

  // Run one start; busy cycles are counted until done shows (bounded).
  task automatic do_op(input logic [1:0] o, input logic f, input int n, input bit scramble,
                       output int busy_cyc, output bit got_done);
    busy_cyc = 0; got_done = 1'b0;
    op = o; ser_in = f; shamt = CNT_W'(n); start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 40; g++) begin
      if (done) begin got_done = 1'b1; break; end
      if (busy) busy_cyc++;
      if (scramble) begin
        op = 2'($urandom); ser_in = 1'($urandom); shamt = CNT_W'($urandom);
        D_in = W'($urandom); en = 1'($urandom); start = 1'($urandom);
      end
      tick();
    end
    en = 1'b0; start = 1'b0;
  endtask

  // Reference: whole-operation result from plain shift/rotate arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] q, input logic [1:0] o,
                                       input logic f, input int n_raw, input logic ser_prev);
    int n;
    bit rot, left;
    logic [W-1:0] r, ones;
    logic s;
    n = (n_raw > W) ? W : n_raw;
    if (n == 0) return {ser_prev, q};
    rot = ROT_EN && o[1];
    left = o[0];
    ones = '1;
    if (rot)
      r = left ? ((q << n) | (q >> (W - n))) : ((q >> n) | (q << (W - n)));
    else if (left)
      r = (q << n) | (f ? ~(ones << n) : '0);
    else
      r = (q >> n) | (f ? ~(ones >> n) : '0);
    s = left ? q[W - n] : q[n - 1];
    return {s, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (Q_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      bad++; $display("FAIL reset_state: Q=%h busy=%b done=%b ser=%b want 00/0/0/0", Q_out, busy, done, ser_out); end
    load(8'hA5);
    total++; if (Q_out !== 8'hA5 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      bad++; $display("FAIL load_a5: Q=%h busy=%b done=%b ser=%b want a5/0/0/0", Q_out, busy, done, ser_out); end
  endtask

  task automatic test_directed();
    int bc; bit gd;
    do_op(2'b00, 1'b0, 3, 1'b0, bc, gd);
    total++; if (!gd || bc != 3 || Q_out !== 8'h14 || ser_out !== 1'b1) begin
      bad++; $display("FAIL shr3: done=%b busy=%0d Q=%h ser=%b want 1/3/14/1", gd, bc, Q_out, ser_out); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse: done=%b want 0", done); end
    load(8'h81);
    do_op(2'b01, 1'b1, 2, 1'b0, bc, gd);
    total++; if (!gd || bc != 2 || Q_out !== 8'h07 || ser_out !== 1'b0) begin
      bad++; $display("FAIL shl2: done=%b busy=%0d Q=%h ser=%b want 1/2/07/0", gd, bc, Q_out, ser_out); end
    load(8'hA5);
    do_op(2'b10, 1'b0, 4, 1'b0, bc, gd);
    total++; if (!gd || bc != 4 || Q_out !== (ROT_EN ? 8'h5A : 8'h0A)) begin
      bad++; $display("FAIL ror4: done=%b busy=%0d Q=%h want 1/4/%h", gd, bc, Q_out, ROT_EN ? 8'h5A : 8'h0A); end
  endtask

  task automatic test_saturate_and_ignore();
    int bc; bit gd; logic [W:0] exp;
    load(8'h3C);
    exp = model(8'h3C, 2'b00, 1'b1, 9, ser_out);
    do_op(2'b00, 1'b1, 9, 1'b1, bc, gd);
    total++; if (!gd || bc != 8 || Q_out !== exp[W-1:0] || ser_out !== exp[W]) begin
      bad++; $display("FAIL sat9: done=%b busy=%0d Q=%h ser=%b want 1/8/%h/%b", gd, bc, Q_out, ser_out, exp[W-1:0], exp[W]); end
    load(8'hC3);
    op = 2'b01; ser_in = 1'b0; shamt = 5; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (Q_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      bad++; $display("FAIL rst_mid: Q=%h busy=%b done=%b ser=%b want 00/0/0/0", Q_out, busy, done, ser_out); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_idle: busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_zero_and_collision();
    logic s0;
    load(8'h5B);
    s0 = ser_out;
    op = 2'b01; ser_in = 1'b1; shamt = 0; start = 1'b1;
    tick(); start = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0 || Q_out !== 8'h5B || ser_out !== s0) begin
      bad++; $display("FAIL zero_amt: done=%b busy=%b Q=%h want 1/0/5b", done, busy, Q_out); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_after: done=%b busy=%b want 0/0", done, busy); end
    en = 1'b1; D_in = 8'hE7; start = 1'b1; shamt = 3; op = 2'b00;
    tick(); en = 1'b0; start = 1'b0;
    total++; if (Q_out !== 8'hE7 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL load_wins: Q=%h busy=%b done=%b want e7/0/0", Q_out, busy, done); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0 || Q_out !== 8'hE7) begin
      bad++; $display("FAIL not_queued: Q=%h busy=%b done=%b want e7/0/0", Q_out, busy, done); end
  endtask

  task automatic test_random();
    int bc, n; bit gd; logic [W:0] exp; logic [1:0] o; logic f; logic [W-1:0] v;
    for (int i = 0; i < 40; i++) begin
      v = W'($urandom); o = 2'($urandom); f = 1'($urandom); n = $urandom_range(0, 15);
      load(v);
      exp = model(v, o, f, n, ser_out);
      do_op(o, f, n, 1'b1, bc, gd);
      total++; if (!gd || bc != ((n > W) ? W : n) || Q_out !== exp[W-1:0] || ser_out !== exp[W]) begin
        bad++; $display("FAIL rnd%0d op=%b n=%0d v=%h: done=%b busy=%0d Q=%h ser=%b want busy=%0d Q=%h ser=%b",
                        i, o, n, v, gd, bc, Q_out, ser_out, (n > W) ? W : n, exp[W-1:0], exp[W]); end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; start = 1'b0; D_in = '0; op = '0; ser_in = 1'b0; shamt = '0;
    test_reset();
    test_directed();
    test_saturate_and_ignore();
    test_zero_and_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
